rs232_avs_uart: RTL and testbench
=================================

RS232_AVS_UART -- requirements
Module: rs232_avs_uart

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the avm_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have port avm_clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port avm_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port avs_address, input, 5 bits: byte address.
REQ-006 The block SHALL have port avs_read, input, 1 bit: read request.
REQ-007 The block SHALL have port avs_readdata, output, 32 bits: read data.
REQ-008 The block SHALL have port avs_write, input, 1 bit: write request.
REQ-009 The block SHALL have port avs_writedata, input, 32 bits: write data; only bits 7:0 are used.
REQ-010 The block SHALL have port avs_waitrequest, output, 1 bit: stall current access.
REQ-011 The block SHALL have port uart_rxd, input, 1 bit: asynchronous serial input.
REQ-012 The block SHALL have port uart_txd, output, 1 bit: serial output.

Function
REQ-013 The register map SHALL be decoded on the full 5-bit address.
- 0 = RX data (bits 7:0).
- 4 = TX data.
- 8 = STATUS: bit7 RRDY, bit6 TRDY, bit8 ROE, bit9 FE; all other bits 0.
REQ-014 Every access SHALL take exactly one wait state.
- Cycle 1 of an access: avs_waitrequest=1.
- Cycle 2: avs_waitrequest=0 and avs_readdata valid (ack cycle).
- A request held past the ack cycle SHALL start a new 2-cycle access.
REQ-015 avs_waitrequest SHALL be 0 whenever avs_read and avs_write are both 0.
REQ-016 Side effects SHALL occur only in the ack cycle:
- RX read pops one byte.
- TX write loads a byte.
- STATUS read clears ROE and FE.
REQ-017 A read of address 4, an unmapped address, or RX while RRDY=0 SHALL return 0. Writes to address 0, address 8, or unmapped addresses SHALL be ignored.
REQ-018 If avs_read and avs_write are both asserted, the access SHALL be treated as a read only.
REQ-019 Baud tick SHALL be generated at 16x BAUD using divisor DIV = round(CLK_HZ/(16*BAUD)) (27 at defaults); one bit time is 16*DIV cycles.
REQ-020 uart_rxd SHALL pass through a 2-flop synchronizer before use.
REQ-021 The RX FSM SHALL use states IDLE, START, DATA, STOP:
- IDLE->START on a synchronized falling edge.
- START->DATA if the line is still low at the half-bit sample; otherwise ->IDLE (glitch reject).
- DATA samples 8 bits LSB-first at bit centres.
- STOP samples the stop bit, then ->IDLE.
REQ-022 In STOP the byte SHALL be stored regardless of the stop value, and FE SHALL be set if the stop bit samples 0.
REQ-023 If RX storage is full at byte completion, the new byte SHALL be dropped and ROE set; the stored data SHALL be unchanged.
REQ-024 When an RX pop ack and a byte completion occur in the same cycle, the new byte SHALL be stored without setting ROE.
REQ-025 The TX FSM SHALL use states IDLE, START, DATA, STOP, each bit lasting 16 ticks, sending LSB-first, with uart_txd=1 in IDLE and STOP.
REQ-026 TRDY SHALL equal 1 only when the TX FSM is in IDLE with no pending byte.
- A TX write with TRDY=0 SHALL be ignored.
- TRDY SHALL fall in the cycle after a TX write ack.
- TRDY SHALL rise after the stop bit completes.

Reset
REQ-027 While avm_rst=1, outputs SHALL be: uart_txd=1, avs_waitrequest=0, avs_readdata=0.
REQ-028 While avm_rst=1, internal state SHALL be: RRDY=0, TRDY=1, ROE=0, FE=0, both FSMs IDLE, RX storage empty, divider counter 0.
REQ-029 Reset asserted mid-frame SHALL abort both FSMs immediately and drive uart_txd=1 asynchronously.

Configuration
REQ-030 With UART_RX_FIFO_EN defined, RX storage SHALL be an 8-entry FIFO.
- RRDY = not empty; full means 8 entries.
- Pointers SHALL wrap modulo 8.
REQ-031 Without UART_RX_FIFO_EN, RX storage SHALL be a single holding register (full = 1 entry).

Verification
REQ-032 Reset, then read STATUS -> waitrequest high for 1 cycle, then readdata=0x00000040.
REQ-033 Drive frame 0xA5 on uart_rxd at 115200 baud -> RRDY=1 within 1 bit time of the stop bit. Then read RX -> 0x000000A5, and a following STATUS read shows RRDY=0.
REQ-034 Write 0x3C to address 4 -> TRDY=0 next cycle; uart_txd shows start, bits 0,0,1,1,1,1,0,0, stop, each 432 cycles; TRDY=1 after the stop bit.
REQ-035 Without UART_RX_FIFO_EN, send 0x11 then 0x22 without reading -> RX read returns 0x11, STATUS shows ROE=1, and a second STATUS read shows ROE=0. With the macro, send 9 bytes -> the first 8 bytes are read in order, ROE=1.
REQ-036 Send frame 0x55 with stop bit 0 -> RRDY=1, FE=1, and RX read returns 0x55.
REQ-037 Pulse uart_rxd low for 100 cycles (< half bit) -> RX FSM returns to IDLE and RRDY stays 0. Assert avm_rst mid-TX -> uart_txd=1 immediately.

Source files
------------

// File: rtl/rs232_avs_uart_if.sv
// rtl/rs232_avs_uart_if.sv - Avalon-MM slave bus bundle for the RS-232 UART register block
interface rs232_avs_uart_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/rs232_avs_uart.sv
// rtl/rs232_avs_uart.sv - RS-232 UART with Avalon-MM register slave, one wait state per access
// Optional macro UART_RX_FIFO_EN: 8-entry RX FIFO instead of a single holding register.
module rs232_avs_uart #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic             avm_clk,
    input  logic             avm_rst,
    rs232_avs_uart_if.slave  avs,
    input  logic             uart_rxd,
    output logic             uart_txd
);

    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    logic        ack_q, acc, rd_ack, wr_ack;
    logic        addr_rx, addr_tx, addr_st;
    logic        rx_pop, status_clr, tx_load;
    logic        rrdy, rx_full, rx_push, trdy;
    logic [7:0]  rx_head;
    logic        roe, fe;
    logic [31:0] rdata;
    logic        unused_wdata;

    // Bus: the first cycle of any request stalls, the second acknowledges.
    assign acc                 = avs.avs_read | avs.avs_write;
    assign avs.avs_waitrequest = acc & ~ack_q & ~avm_rst;
    assign rd_ack              = ack_q & avs.avs_read;
    assign wr_ack              = ack_q & avs.avs_write & ~avs.avs_read;
    assign addr_rx             = (avs.avs_address == 5'd0);
    assign addr_tx             = (avs.avs_address == 5'd4);
    assign addr_st             = (avs.avs_address == 5'd8);
    assign rx_pop              = rd_ack & addr_rx & rrdy;
    assign status_clr          = rd_ack & addr_st;
    assign tx_load             = wr_ack & addr_tx & trdy;
    assign unused_wdata        = ^avs.avs_writedata[31:8];

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) ack_q <= 1'b0;
        else         ack_q <= acc & ~ack_q;
    end

    always_comb begin
        rdata = '0;
        if (rd_ack) begin
            if (addr_rx && rrdy) rdata[7:0] = rx_head;
            if (addr_st) begin
                rdata[9] = fe;
                rdata[8] = roe;
                rdata[7] = rrdy;
                rdata[6] = trdy;
            end
        end
    end
    assign avs.avs_readdata = rdata;

    // ---------------- RX ----------------
    logic            rxd_s1, rxd_s2, rxd_q;
    rx_state_t       rx_state, rx_nx;
    logic [DW-1:0]   rx_div;
    logic [3:0]      rx_tcnt;
    logic [2:0]      rx_bcnt;
    logic [7:0]      rx_shreg;
    logic            rx_tick, rx_shift, rx_done;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_q  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_q  <= rxd_s2;
        end
    end

    assign rx_tick = (rx_div == DIV_LAST);

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) rx_state <= RX_IDLE;
        else         rx_state <= rx_nx;
    end

    always_comb begin
        rx_nx    = rx_state;
        rx_shift = 1'b0;
        rx_done  = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rxd_q && !rxd_s2) rx_nx = RX_START;
            // Half-bit check rejects glitches shorter than 8 ticks.
            RX_START: if (rx_tick && rx_tcnt == 4'd7) rx_nx = rxd_s2 ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tick && rx_tcnt == 4'd15) begin
                    rx_shift = 1'b1;
                    if (rx_bcnt == 3'd7) rx_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tick && rx_tcnt == 4'd15) begin
                    rx_done = 1'b1;
                    rx_nx   = RX_IDLE;
                end
            end
            default: rx_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_div   <= '0;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_shreg <= '0;
        end else if (rx_state == RX_IDLE) begin
            rx_div  <= '0;
            rx_tcnt <= '0;
            rx_bcnt <= '0;
        end else begin
            rx_div <= rx_tick ? '0 : rx_div + DW'(1);
            if (rx_tick)
                rx_tcnt <= (rx_state == RX_START && rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
            if (rx_shift) begin
                rx_shreg <= {rxd_s2, rx_shreg[7:1]};
                rx_bcnt  <= rx_bcnt + 3'd1;
            end
        end
    end

    // A pop in the same cycle frees the slot, so no overrun then.
    assign rx_push = rx_done & (~rx_full | rx_pop);

`ifdef UART_RX_FIFO_EN
    logic [7:0] rx_mem [8];
    logic [2:0] rx_wptr, rx_rptr;
    logic [3:0] rx_cnt;

    assign rrdy    = (rx_cnt != 4'd0);
    assign rx_full = (rx_cnt == 4'd8);
    assign rx_head = rx_mem[rx_rptr];

    always_ff @(posedge avm_clk) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_shreg;
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_wptr <= '0;
            rx_rptr <= '0;
            rx_cnt  <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + 3'd1;
            if (rx_pop)  rx_rptr <= rx_rptr + 3'd1;
            rx_cnt <= rx_cnt + {3'd0, rx_push} - {3'd0, rx_pop};
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_hold_v;

    assign rrdy    = rx_hold_v;
    assign rx_full = rx_hold_v;
    assign rx_head = rx_hold;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            rx_hold   <= '0;
            rx_hold_v <= 1'b0;
        end else if (rx_push) begin
            rx_hold   <= rx_shreg;
            rx_hold_v <= 1'b1;
        end else if (rx_pop) begin
            rx_hold_v <= 1'b0;
        end
    end
`endif

    // New errors win over a simultaneous STATUS-read clear.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            roe <= 1'b0;
            fe  <= 1'b0;
        end else begin
            if (status_clr) begin
                roe <= 1'b0;
                fe  <= 1'b0;
            end
            if (rx_done) begin
                if (!rxd_s2)               fe  <= 1'b1;
                if (rx_full && !rx_pop)    roe <= 1'b1;
            end
        end
    end

    // ---------------- TX ----------------
    tx_state_t       tx_state, tx_nx;
    logic [DW-1:0]   tx_div;
    logic [3:0]      tx_tcnt;
    logic [2:0]      tx_bcnt;
    logic [7:0]      tx_shreg, tx_buf;
    logic            tx_pend, tx_tick, tx_end, tx_shift;

    assign tx_tick = (tx_div == DIV_LAST);
    assign tx_end  = tx_tick && (tx_tcnt == 4'd15);
    assign trdy    = (tx_state == TX_IDLE) && !tx_pend;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) tx_state <= TX_IDLE;
        else         tx_state <= tx_nx;
    end

    always_comb begin
        tx_nx    = tx_state;
        tx_shift = 1'b0;
        case (tx_state)
            TX_IDLE:  if (tx_pend) tx_nx = TX_START;
            TX_START: if (tx_end) tx_nx = TX_DATA;
            TX_DATA: begin
                if (tx_end) begin
                    tx_shift = 1'b1;
                    if (tx_bcnt == 3'd7) tx_nx = TX_STOP;
                end
            end
            TX_STOP:  if (tx_end) tx_nx = TX_IDLE;
            default:  tx_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            tx_pend  <= 1'b0;
            tx_buf   <= '0;
            tx_shreg <= '0;
            tx_div   <= '0;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
        end else begin
            if (tx_load) begin
                tx_pend <= 1'b1;
                tx_buf  <= avs.avs_writedata[7:0];
            end
            if (tx_state == TX_IDLE) begin
                tx_div  <= '0;
                tx_tcnt <= '0;
                tx_bcnt <= '0;
                if (tx_pend) begin
                    tx_shreg <= tx_buf;
                    tx_pend  <= 1'b0;
                end
            end else begin
                tx_div <= tx_tick ? '0 : tx_div + DW'(1);
                if (tx_tick) tx_tcnt <= tx_tcnt + 4'd1;
                if (tx_shift) begin
                    tx_shreg <= {1'b0, tx_shreg[7:1]};
                    tx_bcnt  <= tx_bcnt + 3'd1;
                end
            end
        end
    end

    // Decoded straight from state so reset forces the line idle without a clock.
    assign uart_txd = (tx_state == TX_START) ? 1'b0 :
                      (tx_state == TX_DATA)  ? tx_shreg[0] : 1'b1;

endmodule

// File: tb/tb_rs232_avs_uart.sv
// tb/tb_rs232_avs_uart.sv - scoreboard bench for rs232_avs_uart: register reads, RX/TX frames, errors, reset
module tb_rs232_avs_uart;
    localparam int BIT = 432;

    logic avm_clk = 1'b0;
    logic avm_rst = 1'b1;
    logic uart_rxd = 1'b1;
    logic uart_txd;

    rs232_avs_uart_if bus();

    rs232_avs_uart dut (
        .avm_clk  (avm_clk),
        .avm_rst  (avm_rst),
        .avs      (bus),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd)
    );

    always #10 avm_clk = ~avm_clk;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Read-data monitor: every ack cycle of a read pops one expectation.
    always @(negedge avm_clk) begin
        exp_t e;
        if (!avm_rst && bus.avs_read && !bus.avs_waitrequest) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got %h expected no ack", bus.avs_readdata);
            end else begin
                e = sb.pop_front();
                chk(e.name, bus.avs_readdata, e.data);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge avm_clk);
        #1;
    endtask

    task automatic bus_acc(input logic rd, input logic wr, input logic [4:0] a,
                           input logic [31:0] wd, input logic [31:0] exp, input string nm);
        cycles(1);
        bus.avs_address   = a;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_writedata = wd;
        if (rd) sb.push_back('{nm, exp});
        #1;
        chk({nm, "_ws1"}, {31'd0, bus.avs_waitrequest}, 32'd1);
        cycles(1);
        chk({nm, "_ws0"}, {31'd0, bus.avs_waitrequest}, 32'd0);
        cycles(1);
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            cycles(BIT);
        end
        uart_rxd = stop_bit;
        cycles(BIT);
        uart_rxd = 1'b1;
        cycles(32);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        logic       exp_bit;
        bus.avs_address   = 5'd8;
        bus.avs_read      = 1'b1;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;

        // Outputs under reset, even with a read pending
        cycles(5);
        chk("rst_waitreq", {31'd0, bus.avs_waitrequest}, 32'd0);
        chk("rst_readdata", bus.avs_readdata, 32'd0);
        chk("rst_txd", {31'd0, uart_txd}, 32'd1);
        bus.avs_read = 1'b0;
        avm_rst = 1'b0;
        cycles(2);

        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_reset");

        // RX 0xA5
        send_frame(8'hA5, 1'b1);
        bus_acc(1, 0, 5'd8, 0, 32'hC0, "st_rrdy");
        bus_acc(1, 0, 5'd0, 0, 32'hA5, "rx_a5");
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_popped");
        bus_acc(1, 0, 5'd0, 0, 32'h0, "rx_empty");
        bus_acc(1, 0, 5'd4, 0, 32'h0, "rd_tx_addr");
        bus_acc(1, 0, 5'd12, 0, 32'h0, "rd_unmapped");
        bus_acc(1, 0, 5'd28, 0, 32'h0, "rd_unmapped_hi");

        // Read+write together is a read only: no TX load
        bus_acc(1, 1, 5'd4, 32'h5A, 32'h0, "rdwr_tx");
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_after_rdwr");
        chk("txd_after_rdwr", {31'd0, uart_txd}, 32'd1);
        bus_acc(0, 1, 5'd8, 32'hFF, 32'h0, "wr_status");
        bus_acc(0, 1, 5'd0, 32'hFF, 32'h0, "wr_rx");
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_after_wr_ign");

        // TX 0x3C; n counts cycles from entry into the start bit
        pat = {1'b1, 8'h3C, 1'b0};
        bus_acc(0, 1, 5'd4, 32'h3C, 32'h0, "tx_wr");
        fork
            begin
                for (int n = 0; n <= 4540; n++) begin
                    cycles(1);
                    if ((n % BIT) == BIT / 2 || n == 1295 || n == 1296 || n == 3887 ||
                        n == 3888 || n == 4319 || n == 4540) begin
                        exp_bit = (n < 10 * BIT) ? pat[n / BIT] : 1'b1;
                        chk($sformatf("txd_n%0d", n), {31'd0, uart_txd}, {31'd0, exp_bit});
                    end
                end
            end
            begin
                bus_acc(1, 0, 5'd8, 0, 32'h0, "st_tx_busy");
                bus_acc(0, 1, 5'd4, 32'hFF, 32'h0, "tx_busy_wr");
            end
        join
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_tx_done");

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        for (int i = 1; i <= 8; i++) bus_acc(1, 0, 5'd0, 0, 32'(i), $sformatf("rx_fifo%0d", i));
        bus_acc(1, 0, 5'd8, 0, 32'h140, "st_roe");
`else
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        bus_acc(1, 0, 5'd0, 0, 32'h11, "rx_11");
        bus_acc(1, 0, 5'd8, 0, 32'h140, "st_roe");
`endif
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_roe_clr");

        // Framing error
        send_frame(8'h55, 1'b0);
        bus_acc(1, 0, 5'd8, 0, 32'h2C0, "st_fe");
        bus_acc(1, 0, 5'd0, 0, 32'h55, "rx_55");
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_fe_clr");

        // Glitch shorter than half a bit
        uart_rxd = 1'b0;
        cycles(100);
        uart_rxd = 1'b1;
        cycles(1000);
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_glitch");
        bus_acc(1, 0, 5'd0, 0, 32'h0, "rx_glitch");

        // Reset mid-frame
        bus_acc(0, 1, 5'd4, 32'h00, 32'h0, "tx_wr00");
        cycles(1000);
        chk("txd_mid", {31'd0, uart_txd}, 32'd0);
        @(negedge avm_clk);
        avm_rst = 1'b1;
        #1;
        chk("txd_rst_async", {31'd0, uart_txd}, 32'd1);
        cycles(3);
        avm_rst = 1'b0;
        cycles(2);
        bus_acc(1, 0, 5'd8, 0, 32'h40, "st_after_rst");
        cycles(500);
        chk("txd_after_rst", {31'd0, uart_txd}, 32'd1);

        cycles(4);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
